// File: rtl/tc_job_ctrl.sv
// tc_job_ctrl: job sequencer for the tensor core. Streams A/B/C operand rows
// into the core buffers, fires compute, and queues the returned D rows in a
// show-ahead FIFO that drains to a backpressured output stream.
module tc_job_ctrl #(
  parameter int M       = 16,
  parameter int DW_MEM  = 512,
  parameter int DW_IDX  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [DW_MEM-1:0] rd_data,
  output logic              load_en,
  output logic              compute_en,
  output logic              write_a,
  output logic              write_b,
  output logic              write_c,
  output logic [DW_MEM-1:0] wr_data,
  output logic [DW_IDX-1:0] wr_row,
  input  logic              core_out_valid,
  input  logic [DW_MEM-1:0] core_d_row,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [DW_MEM-1:0] d_data,
  output logic              d_last
);

  localparam int CW = DW_IDX + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     M_CNT    = CW'(M);
  localparam logic [CW-1:0]     LAST_POP = CW'(M - 1);
  localparam logic [DW_IDX-1:0] LAST_IDX = DW_IDX'(M - 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    LOAD_C = 3'd3,
    FIRE   = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  state_t              state;
  logic [DW_IDX-1:0]   row_cnt;
  logic [CW-1:0]       out_cnt;
  logic [CW-1:0]       out_cnt_nxt;
  logic [TW-1:0]       tmo_cnt;

  logic [DW_MEM-1:0]   fifo_mem [M];
  logic [DW_IDX-1:0]   wr_ptr;
  logic [DW_IDX-1:0]   rd_ptr;
  logic [CW-1:0]       fifo_cnt;
  logic [CW-1:0]       pop_cnt;

  logic                in_load;
  logic                rd_hs;
  logic                accept;
  logic                pop;
  logic                tmo_hit;
  logic                drain_done;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [DW_IDX-1:0] ptr_inc(input logic [DW_IDX-1:0] p);
    return (p == LAST_IDX) ? '0 : p + DW_IDX'(1);
  endfunction

  assign in_load     = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
  assign busy        = (state != IDLE);
  assign rd_ready    = in_load;
  assign load_en     = in_load;
  assign rd_hs       = rd_valid && in_load;
  // Only the first M D rows of a DRAIN are kept; anything else is dropped.
  assign accept      = core_out_valid && (state == DRAIN) && (out_cnt < M_CNT);
  assign pop         = d_valid && d_ready;
  assign out_cnt_nxt = out_cnt + CW'(accept);
  // A row landing in the final allowed cycle still counts as on time.
  assign tmo_hit     = (state == DRAIN) && (tmo_cnt == TMO_LAST) && (out_cnt_nxt < M_CNT);
  assign drain_done  = (state == DRAIN) && (out_cnt == M_CNT) && (fifo_cnt == '0);

  assign d_valid     = (fifo_cnt != '0);
  assign d_data      = fifo_mem[rd_ptr];
  assign d_last      = d_valid && (pop_cnt == LAST_POP);

  // Job FSM: operand-row writes and compute pulse are registered one cycle after their cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row_cnt    <= '0;
      out_cnt    <= '0;
      tmo_cnt    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      compute_en <= 1'b0;
      write_a    <= 1'b0;
      write_b    <= 1'b0;
      write_c    <= 1'b0;
      wr_data    <= '0;
      wr_row     <= '0;
    end else begin
      done       <= 1'b0;
      compute_en <= 1'b0;
      write_a    <= 1'b0;
      write_b    <= 1'b0;
      write_c    <= 1'b0;

      if (rd_hs) begin
        wr_data <= rd_data;
        wr_row  <= row_cnt;
        row_cnt <= (row_cnt == LAST_IDX) ? '0 : row_cnt + DW_IDX'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD_A;
            row_cnt <= '0;
            err     <= 1'b0;
          end
        end
        LOAD_A: begin
          if (rd_hs) begin
            write_a <= 1'b1;
            if (row_cnt == LAST_IDX) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (rd_hs) begin
            write_b <= 1'b1;
            if (row_cnt == LAST_IDX) state <= LOAD_C;
          end
        end
        LOAD_C: begin
          if (rd_hs) begin
            write_c <= 1'b1;
            if (row_cnt == LAST_IDX) state <= FIRE;
          end
        end
        FIRE: begin
          compute_en <= 1'b1;
          out_cnt    <= '0;
          tmo_cnt    <= '0;
          state      <= DRAIN;
        end
        DRAIN: begin
          out_cnt <= out_cnt_nxt;
          tmo_cnt <= tmo_cnt + TW'(1);
          if (tmo_hit) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end else if (drain_done) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (core_out_valid && !accept) err <= 1'b1;
    end
  end

  // D-row FIFO control: pointers, occupancy and per-job pop count; timeout flushes it.
  always_ff @(posedge clk) begin
    if (reset || tmo_hit) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      pop_cnt  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      if (state == FIRE)
        pop_cnt <= '0;
      else if (pop)
        pop_cnt <= pop_cnt + CW'(1);
      case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // D-row FIFO storage.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= core_d_row;
  end

endmodule

// File: tb/tb_tc_job_ctrl.sv
// Directed bench for tc_job_ctrl: nominal job, read bubbles with output
// backpressure, spurious core output, timeout, and reset in mid-job.
module tb_tc_job_ctrl;
  localparam int M  = 16;
  localparam int DW = 16;
  localparam int DI = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          core_out_valid;
  logic [DW-1:0] core_d_row;
  logic          d_ready;

  logic          busy, done, err, rd_ready, load_en, compute_en;
  logic          write_a, write_b, write_c, d_valid, d_last;
  logic [DW-1:0] wr_data, d_data;
  logic [DI-1:0] wr_row;

  logic          t_busy, t_done, t_err, t_rd_ready, t_load_en, t_compute_en;
  logic          t_write_a, t_write_b, t_write_c, t_d_valid, t_d_last;
  logic [DW-1:0] t_wr_data, t_d_data;
  logic [DI-1:0] t_wr_row;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int popn = 0;
  int last_pop = 0;

  always #5 clk = ~clk;

  tc_job_ctrl #(.M(M), .DW_MEM(DW), .DW_IDX(DI)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .load_en(load_en), .compute_en(compute_en),
    .write_a(write_a), .write_b(write_b), .write_c(write_c),
    .wr_data(wr_data), .wr_row(wr_row),
    .core_out_valid(core_out_valid), .core_d_row(core_d_row),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_last(d_last)
  );

  tc_job_ctrl #(.M(M), .DW_MEM(DW), .DW_IDX(DI), .TIMEOUT(20)) dut_t (
    .clk(clk), .reset(reset), .start(start), .busy(t_busy), .done(t_done), .err(t_err),
    .rd_valid(rd_valid), .rd_ready(t_rd_ready), .rd_data(rd_data),
    .load_en(t_load_en), .compute_en(t_compute_en),
    .write_a(t_write_a), .write_b(t_write_b), .write_c(t_write_c),
    .wr_data(t_wr_data), .wr_row(t_wr_row),
    .core_out_valid(core_out_valid), .core_d_row(core_d_row),
    .d_valid(t_d_valid), .d_ready(d_ready), .d_data(t_d_data), .d_last(t_d_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  // Advance one cycle, checking any D row popped in the current cycle.
  task automatic step();
    if (d_valid && d_ready) begin
      chk("d_data", d_data, 32'h100 + popn);
      chk("d_last", d_last, (popn == M - 1));
      popn++;
      last_pop = cyc_cnt;
    end
    cyc();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, err, rd_ready, load_en, compute_en,
                        write_a, write_b, write_c, d_valid, d_last}, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_wr_row"}, wr_row, 0);
  endtask

  task automatic start_job();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err", err, 0);
    chk("start_done", done, 0);
  endtask

  // Present rows 0..stop-1 on the read stream and check the operand writes.
  task automatic load(input int stop, input bit bubble, input int spur_at);
    int n = 0;
    int k = 0;
    bit ea, eb, ec;
    while (n < stop) begin
      rd_valid = bubble ? (k % 2 == 0) : 1'b1;
      rd_data = DW'(n);
      core_out_valid = (k == spur_at);
      chk("rd_ready", rd_ready, 1);
      chk("load_en", load_en, 1);
      ea = rd_valid && (n < 16);
      eb = rd_valid && (n >= 16) && (n < 32);
      ec = rd_valid && (n >= 32);
      cyc();
      k++;
      chk("write_abc", {write_a, write_b, write_c}, {ea, eb, ec});
      if (rd_valid) begin
        chk("wr_row", wr_row, n % M);
        chk("wr_data", wr_data, n);
        n++;
      end
      if (core_out_valid) chk("spur_err", err, 1);
      core_out_valid = 1'b0;
    end
    rd_valid = 1'b0;
  endtask

  // Called in the cycle after the final C handshake; returns in the compute_en cycle.
  task automatic fire_chk();
    chk("fire_load_en", load_en, 0);
    chk("fire_rd_ready", rd_ready, 0);
    chk("fire_cen_early", compute_en, 0);
    chk("fire_write_c", write_c, 1);
    cyc();
    chk("compute_en", compute_en, 1);
    chk("write_c_off", write_c, 0);
  endtask

  task automatic run_job(input bit bubble, input int spur_at, input int delay,
                         input bit bp, input bit exp_err);
    int guard = 0;
    start_job();
    load(3 * M, bubble, spur_at);
    fire_chk();
    popn = 0;
    d_ready = !bp;
    repeat (delay) step();
    for (int i = 0; i < M; i++) begin
      core_out_valid = 1'b1;
      core_d_row = DW'(32'h100 + i);
      if (bp && i > 0) begin
        chk("hold_valid", d_valid, 1);
        chk("hold_data", d_data, 32'h100);
        chk("hold_last", d_last, 0);
      end
      step();
      if (i == 0) chk("d_valid_lat", d_valid, 1);
    end
    core_out_valid = 1'b0;
    if (bp) chk("bp_err", err, exp_err);
    d_ready = 1'b1;
    while (done !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_err", err, exp_err);
    chk("rows", popn, M);
    chk("done_gap", cyc_cnt - last_pop, 2);
    chk("done_dvalid", d_valid, 0);
    step();
    chk("done_pulse", done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rd_valid = 1'b0;
    rd_data = '0;
    core_out_valid = 1'b0;
    core_d_row = '0;
    d_ready = 1'b1;
    cyc();
    cyc();
    chk_zero("rst");
    chk("t_rst_ctl", {t_busy, t_done, t_err, t_rd_ready, t_load_en, t_compute_en,
                      t_write_a, t_write_b, t_write_c, t_d_valid, t_d_last}, 0);
    chk("t_rst_wr_data", t_wr_data, 0);
    chk("t_rst_wr_row", t_wr_row, 0);
    reset = 1'b0;
    cyc();

    // Nominal job, core answers 5 cycles after compute_en.
    run_job(1'b0, -1, 5, 1'b0, 1'b0);
    // Read bubbles, and all 16 rows held under backpressure.
    run_job(1'b1, -1, 1, 1'b1, 1'b0);
    // Spurious core beat during LOAD_B (row 20 of the stream).
    run_job(1'b0, 20, 1, 1'b0, 1'b1);

    // Timeout on the TIMEOUT=20 instance: only 3 rows arrive, held in the FIFO.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    start_job();
    load(3 * M, 1'b0, -1);
    fire_chk();
    d_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      core_out_valid = 1'b1;
      core_d_row = DW'(32'h100 + i);
      cyc();
    end
    core_out_valid = 1'b0;
    repeat (15) cyc();
    chk("tmo_pre_done", t_done, 0);
    chk("tmo_pre_err", t_err, 0);
    chk("tmo_pre_dvalid", t_d_valid, 1);
    chk("tmo_pre_ddata", t_d_data, 32'h100);
    chk("tmo_pre_busy", t_busy, 1);
    cyc();
    chk("tmo_done", t_done, 1);
    chk("tmo_err", t_err, 1);
    chk("tmo_flush", t_d_valid, 0);
    chk("tmo_busy", t_busy, 0);
    chk("long_tmo_done", done, 0);
    chk("long_tmo_err", err, 0);
    chk("long_tmo_dvalid", d_valid, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("tmo_restart_err", t_err, 0);
    chk("tmo_restart_busy", t_busy, 1);
    chk("tmo_restart_done", t_done, 0);
    chk("tmo_restart_rdy", t_rd_ready, 1);
    d_ready = 1'b1;
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // Reset on the handshake of C row 7.
    start_job();
    load(39, 1'b0, -1);
    rd_valid = 1'b1;
    rd_data = DW'(39);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd_valid = 1'b0;
    chk_zero("rst_loadc");

    // Reset in DRAIN with 4 rows queued.
    start_job();
    load(3 * M, 1'b0, -1);
    fire_chk();
    d_ready = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      core_out_valid = 1'b1;
      core_d_row = DW'(32'h200 + i);
      cyc();
    end
    core_out_valid = 1'b0;
    chk("q4_valid", d_valid, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    d_ready = 1'b1;
    chk_zero("rst_drain");

    // A full job after the mid-job resets.
    run_job(1'b0, -1, 5, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tc_job_ctrl.md
# tc_job_ctrl

Job-level sequencer for the tensor-core datapath. It accepts a start command, pulls the A, B and C row images (M rows each) from a valid/ready read stream, and writes them into the core's operand buffers. It then fires the core's compute, and collects the M D rows the core emits into an internal FIFO, which drains to a backpressured output stream. It sits between the memory/DMA front end and the core, and is the only agent driving the core's load/compute controls.

## Interface
Parameters:
- M, 16, rows per operand matrix and per D result
- DW_MEM, 512, row width in bits
- DW_IDX, 4, row index width (2^DW_IDX ≥ M)
- TIMEOUT, 1023, max cycles from compute_en to the M-th D row

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin job (sampled only in IDLE)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end (success or error)
- err  out  1  sticky error flag, cleared by an accepted start
- rd_valid  in  1  read-stream beat valid
- rd_ready  out  1  read-stream ready
- rd_data  in  DW_MEM  row data; order is A rows 0..M-1, B rows 0..M-1, C rows 0..M-1
- load_en  out  1  core load phase
- compute_en  out  1  core compute pulse
- write_a / write_b / write_c  out  1 each  core operand-row write strobes
- wr_data  out  DW_MEM  row data, shared by all three write strobes
- wr_row  out  DW_IDX  row index for the active strobe
- core_out_valid  in  1  core D-row valid (no backpressure possible)
- core_d_row  in  DW_MEM  core D row
- d_valid  out  1  output-stream valid
- d_ready  in  1  output-stream ready
- d_data  out  DW_MEM  output row
- d_last  out  1  high with the M-th row of the job

## Operation
- States: IDLE, LOAD_A, LOAD_B, LOAD_C, FIRE, DRAIN.
- IDLE, start=1: go to LOAD_A, set row_cnt=0, clear err. Otherwise stay in IDLE. start is ignored in all other states.
- LOAD_x:
  - rd_ready=1 and load_en=1.
  - Each handshake (rd_valid&rd_ready) registers write_x=1, wr_data=rd_data and wr_row=row_cnt for the next cycle, then increments row_cnt.
  - On the handshake with row_cnt=M-1: wrap row_cnt to 0 and advance LOAD_A→LOAD_B→LOAD_C→FIRE.
- FIRE (one cycle): load_en=0 and rd_ready=0. compute_en is registered high for exactly the following cycle. Clear out_cnt and tmo_cnt, then go to DRAIN.
- DRAIN:
  - Each core_out_valid pushes core_d_row into the FIFO and increments out_cnt.
  - tmo_cnt increments every cycle.
  - Exit when out_cnt==M and the FIFO is empty: pulse done and go to IDLE.
- FIFO:
  - Depth M, show-ahead. d_valid = !empty, d_data = head.
  - Pop on d_valid&d_ready. Simultaneous push and pop is legal, and occupancy is unchanged.
  - Depth M means the FIFO cannot overflow within one job.
- d_last is high when the head is row M-1 of the job. Track this with a pop counter.
- Error conditions. Each sets err=1:
  - tmo_cnt reaches TIMEOUT with out_cnt<M. In that case: flush the FIFO, pulse done, go to IDLE.
  - core_out_valid while out_cnt==M, or in any state other than DRAIN. The beat is dropped and the state is unaffected.
- Reset, including mid-job:
  - State goes to IDLE, all counters to 0, FIFO emptied.
  - Every output goes to 0: busy, done, err, rd_ready, load_en, compute_en, write_*, wr_data, wr_row, d_valid, d_last.
  - d_data is don't-care while d_valid=0.

## Timing
- Operand writes: a handshake in cycle t gives write_x/wr_data/wr_row valid in cycle t+1, exactly one cycle.
- Read stream: full throughput, one row per cycle with rd_valid held high. A bubble on rd_valid produces a bubble on write_x.
- Compute start: if the final C handshake is in cycle T, then write_c is high in T+1 and compute_en is high in T+2. load_en is low from T+1.
- Job length: the minimum from start to compute_en is 3M+2 cycles.
- Output stream: a core_out_valid in cycle t gives d_valid in t+1 if the FIFO was empty.
- Job end: done is high in the cycle after the FIFO empties with out_cnt==M. busy drops in that same cycle.
- d_valid with d_ready=0: d_data and d_last hold stable.

## Test plan
- Nominal job:
  - Stimulus: start; 48 rows with rd_data=row number, rd_valid always high; core returns 16 rows with core_d_row=0x100+i starting 5 cycles after compute_en; d_ready=1.
  - Required: write_a/b/c each high for 16 consecutive cycles with wr_row 0..15; compute_en a single pulse 2 cycles after the last rd handshake; d_data=0x100..0x10F; d_last only on 0x10F; done=1, err=0.
- Read bubbles:
  - Stimulus: rd_valid toggles 1/0.
  - Required: write_* is high only in cycles following handshakes; wr_row stays contiguous 0..15.
- Output backpressure:
  - Stimulus: d_ready=0 while the core emits 16 rows back-to-back, then d_ready=1.
  - Required: FIFO holds all 16 rows with no err; rows drain in order; done comes after the 16th pop.
- Timeout:
  - Stimulus: TIMEOUT=20; core emits only 3 rows.
  - Required: err=1 and a done pulse at the 20th DRAIN cycle; FIFO flushed (d_valid=0); next start clears err.
- Spurious output:
  - Stimulus: core_out_valid pulsed in LOAD_B.
  - Required: err=1; the job otherwise completes with 16 correct rows.
- Reset mid-job:
  - Stimulus: assert reset in LOAD_C row 7 and again in DRAIN with 4 rows queued.
  - Required: the next cycle has every output 0 and busy=0; a following full job completes normally.
